dma_mem_arbiter: RTL
====================

# dma_mem_arbiter

Shares the single 8-bit system memory port between the CPU and the 8-bit DMA channel. Each requester and the memory side use toggle handshakes: a transfer is pending while request and acknowledge levels differ. DMA requests win by default. A burst limit guarantees the CPU one access after a bounded number of consecutive DMA grants. Sits between the CPU bus/DMA8 controller and the memory controller.

## Interface
- MAX_DMA_BURST, 4: consecutive DMA grants allowed while a CPU request is pending (legal range 1..15).
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_addr  in  24  CPU address, stable while CPU request pending
- cpu_we  in  1  1 = write, 0 = read; stable while pending
- cpu_wdata  in  8  CPU write data; stable while pending
- cpu_req  in  1  CPU request toggle
- cpu_ack  out  1  CPU acknowledge toggle
- cpu_rdata  out  8  CPU read data, valid when cpu_ack == cpu_req
- dma_addr  in  24  DMA address, stable while pending
- dma_we  in  1  DMA write enable
- dma_wdata  in  8  DMA write data
- dma_req  in  1  DMA request toggle
- dma_ack  out  1  DMA acknowledge toggle
- dma_rdata  out  8  DMA read data, valid when dma_ack == dma_req
- mem_addr  out  24  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  8  memory write data
- mem_req  out  1  memory request toggle
- mem_ack  in  1  memory acknowledge toggle
- mem_rdata  in  8  memory read data, valid when mem_ack == mem_req
- busy  out  1  1 while in S_BUSY
- owner  out  1  0 = CPU, 1 = DMA; last granted requester

## Operation
- Pending flags: cpu_pend = cpu_req ^ cpu_ack, dma_pend = dma_req ^ dma_ack.
- States: S_IDLE, S_BUSY.
- S_IDLE selects a requester:
  - no pending request: stay in S_IDLE.
  - only one pending: grant it.
  - both pending: grant CPU if burst_cnt == MAX_DMA_BURST, otherwise grant DMA.
- On grant:
  - latch the granted addr/we/wdata into mem_addr/mem_we/mem_wdata.
  - set owner.
  - invert mem_req.
  - move to S_BUSY.
- burst_cnt (4-bit) update at each grant:
  - DMA granted while cpu_pend = 1: increment.
  - DMA granted with cpu_pend = 0: clear to 0.
  - CPU granted: clear to 0.
- S_BUSY, while mem_ack != mem_req: hold all mem_* outputs.
- S_BUSY, when mem_ack == mem_req:
  - if mem_we = 0, copy mem_rdata into the owner's rdata register. Writes leave rdata unchanged.
  - invert the owner's ack.
  - return to S_IDLE.
- Non-owner rdata and ack never change.
- Requester contract:
  - toggle req only when req == ack.
  - toggling while pending is illegal and not detected.
- Reset:
  - state = S_IDLE, burst_cnt = 0.
  - cpu_ack, dma_ack, mem_req, mem_we, busy, owner = 0.
  - mem_addr = 0, mem_wdata = 0, cpu_rdata = 0, dma_rdata = 0.
- Reset mid-transfer abandons the access without an ack. The memory controller and requesters share the same reset, so all toggles restart at 0.

## Timing
- Request toggled before edge N (seen pending in cycle N, state S_IDLE): mem_req flips at edge N+1.
- mem_ack matching in cycle M: owner ack and rdata update at edge M+1, state returns to S_IDLE at M+1.
- Arbiter overhead is 2 cycles plus memory latency. Zero-wait memory (ack one cycle after req) gives requester turnaround of 3 cycles.
- The pending flag of the served requester clears at M+1, so S_IDLE at M+1 never re-grants the same transaction.
- Back-to-back grants: a new grant can occur in the first S_IDLE cycle after completion. There is no extra idle cycle.
- A request arriving in the same cycle as completion is evaluated in the following S_IDLE cycle.

## Test plan
- Single CPU read, addr 0x012345, memory returns 0xA5 two cycles after mem_req flip -> mem_addr = 0x012345, mem_we = 0; cpu_ack flips with cpu_rdata = 0xA5; dma_ack unchanged.
- DMA write, addr 0x0F0002, data 0x3C -> mem_we = 1, mem_wdata = 0x3C; dma_ack flips; dma_rdata keeps its previous value.
- CPU and DMA toggled in the same cycle, DMA re-requesting immediately after each ack, MAX_DMA_BURST = 4 -> grant order DMA, DMA, DMA, DMA, CPU, then DMA resumes with burst_cnt = 0.
- Zero-wait memory, CPU-only stream of 5 reads -> each ack arrives 3 cycles after its req toggle; exactly 5 mem_req toggles.
- Reset asserted in S_BUSY with mem_ack withheld -> next cycle all outputs at reset values, busy = 0, no ack toggle. A fresh request after reset completes normally.

Source files
------------

// File: rtl/dma_mem_arbiter.sv
// Arbitrates the single 8-bit memory port between the CPU and the DMA8 channel.
// All three sides use toggle handshakes; DMA wins unless its burst allowance is spent.
module dma_mem_arbiter #(
   parameter int MAX_DMA_BURST = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] cpu_addr,
   input  logic        cpu_we,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_req,
   output logic        cpu_ack,
   output logic [7:0]  cpu_rdata,
   input  logic [23:0] dma_addr,
   input  logic        dma_we,
   input  logic [7:0]  dma_wdata,
   input  logic        dma_req,
   output logic        dma_ack,
   output logic [7:0]  dma_rdata,
   output logic [23:0] mem_addr,
   output logic        mem_we,
   output logic [7:0]  mem_wdata,
   output logic        mem_req,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata,
   output logic        busy,
   output logic        owner
);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   localparam logic [3:0] BURST_MAX = 4'(MAX_DMA_BURST);

   state_t      state_q, state_d;
   logic [3:0]  burst_q, burst_d;
   logic        cpu_ack_q, cpu_ack_d;
   logic        dma_ack_q, dma_ack_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic        owner_q, owner_d;
   logic [23:0] mem_addr_q, mem_addr_d;
   logic [7:0]  mem_wdata_q, mem_wdata_d;
   logic [7:0]  cpu_rdata_q, cpu_rdata_d;
   logic [7:0]  dma_rdata_q, dma_rdata_d;

   logic cpu_pend, dma_pend, grant_dma;

   assign cpu_pend  = cpu_req ^ cpu_ack_q;
   assign dma_pend  = dma_req ^ dma_ack_q;
   // CPU only pre-empts once DMA has used its full burst allowance
   assign grant_dma = dma_pend && !(cpu_pend && burst_q == BURST_MAX);

   always_comb begin
      state_d     = state_q;
      burst_d     = burst_q;
      cpu_ack_d   = cpu_ack_q;
      dma_ack_d   = dma_ack_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      owner_d     = owner_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dma_rdata_d = dma_rdata_q;
      case (state_q)
         S_IDLE: begin
            if (cpu_pend || dma_pend) begin
               owner_d     = grant_dma;
               mem_addr_d  = grant_dma ? dma_addr  : cpu_addr;
               mem_we_d    = grant_dma ? dma_we    : cpu_we;
               mem_wdata_d = grant_dma ? dma_wdata : cpu_wdata;
               mem_req_d   = ~mem_req_q;
               state_d     = S_BUSY;
               if (grant_dma && cpu_pend) burst_d = burst_q + 4'd1;
               else                       burst_d = 4'd0;
            end
         end
         S_BUSY: begin
            if (mem_ack == mem_req_q) begin
               if (owner_q) begin
                  dma_ack_d = ~dma_ack_q;
                  if (!mem_we_q) dma_rdata_d = mem_rdata;
               end else begin
                  cpu_ack_d = ~cpu_ack_q;
                  if (!mem_we_q) cpu_rdata_d = mem_rdata;
               end
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         burst_q     <= 4'd0;
         cpu_ack_q   <= 1'b0;
         dma_ack_q   <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         owner_q     <= 1'b0;
         mem_addr_q  <= 24'd0;
         mem_wdata_q <= 8'd0;
         cpu_rdata_q <= 8'd0;
         dma_rdata_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         burst_q     <= burst_d;
         cpu_ack_q   <= cpu_ack_d;
         dma_ack_q   <= dma_ack_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         owner_q     <= owner_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
      end
   end

   assign cpu_ack   = cpu_ack_q;
   assign dma_ack   = dma_ack_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dma_rdata = dma_rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_we    = mem_we_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_req   = mem_req_q;
   assign owner     = owner_q;
   assign busy      = (state_q == S_BUSY);

endmodule
